// File: rtl/sw_led_ctrl.sv
// Switch-to-LED controller: two-flop synchroniser, per-channel debounce, rising-edge
// pulses and a registered LED drive with four display modes. Blink built with SW_LED_BLINK_EN.
module sw_led_ctrl #(
  parameter int WIDTH             = 7,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int BLINK_HALF_PERIOD = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] sw_db_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] led_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  generate
    if (WIDTH < 1 || DEBOUNCE_CYCLES < 1 || BLINK_HALF_PERIOD < 1) begin : g_bad_param
      $error("sw_led_ctrl: all parameters must be >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] tgl;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] db_next;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] led_next;

  // A channel flips only after its synchronised level has disagreed with the
  // debounced level for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    db_next = sw_db_o;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != sw_db_o[i]) begin
        if (cnt[i] == CNT_LAST) begin
          db_next[i] = ~sw_db_o[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
    rise_next = db_next & ~sw_db_o;
  end

`ifdef SW_LED_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end
`endif

  always_comb begin
    led_next = '0;
    unique case (mode_i)
      2'b00: led_next = sw_db_o;
      2'b01: led_next = tgl;
`ifdef SW_LED_BLINK_EN
      2'b10: led_next = blink_phase ? sw_db_o : '0;
`else
      2'b10: led_next = sw_db_o;
`endif
      default: led_next = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1      <= '0;
      s2      <= '0;
      sw_db_o <= '0;
      rise_o  <= '0;
      tgl     <= '0;
      led_o   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1      <= sw_i;
      s2      <= s1;
      sw_db_o <= db_next;
      rise_o  <= rise_next;
      // Toggle state tracks presses in every mode so switching to toggle shows history.
      tgl     <= tgl ^ rise_next;
      led_o   <= led_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Self-checking bench for sw_led_ctrl: window-based behavioural model checked every
// cycle plus directed literal checks. Honours SW_LED_BLINK_EN like the design.
module tb_sw_led_ctrl;

  localparam int W  = 7;
  localparam int DC = 4;
  localparam int HP = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw;
  logic [1:0]   mode;
  logic [W-1:0] sw_db;
  logic [W-1:0] rise;
  logic [W-1:0] led;

  int n_cmp = 0;
  int n_bad = 0;

  sw_led_ctrl #(
    .WIDTH            (W),
    .DEBOUNCE_CYCLES  (DC),
    .BLINK_HALF_PERIOD(HP)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .sw_i   (sw),
    .mode_i (mode),
    .sw_db_o(sw_db),
    .rise_o (rise),
    .led_o  (led)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // model: a channel's debounced level flips when the last DC synchronised
  // samples all disagree with it and no flip/reset happened inside that window
  logic         model_valid = 1'b0;
  logic [W-1:0] s1m, s2m, dbm, risem, tglm, ledm;
  logic [W-1:0] s2_hist[$];
  int           last_flip[W];
  int           n_edges;

  always @(posedge clk) begin
    logic [W-1:0] led_new, flip, smp;
    logic         phase, all_diff;
    if (rst) begin
      s1m = '0; s2m = '0; dbm = '0; risem = '0; tglm = '0; ledm = '0;
      s2_hist.delete();
      n_edges = 0;
      for (int i = 0; i < W; i++) last_flip[i] = 0;
      model_valid = 1'b1;
    end else begin
      phase = ((n_edges / HP) % 2) == 0;
      case (mode)
        2'd0: led_new = dbm;
        2'd1: led_new = tglm;
`ifdef SW_LED_BLINK_EN
        2'd2: led_new = phase ? dbm : '0;
`else
        2'd2: led_new = dbm;
`endif
        default: led_new = '0;
      endcase
      s2_hist.push_back(s2m);
      if (s2_hist.size() > DC) void'(s2_hist.pop_front());
      n_edges++;
      flip = '0;
      for (int i = 0; i < W; i++) begin
        if (n_edges - last_flip[i] >= DC) begin
          all_diff = 1'b1;
          for (int k = 0; k < DC; k++) begin
            smp = s2_hist[k];
            if (smp[i] == dbm[i]) all_diff = 1'b0;
          end
          if (all_diff) begin
            flip[i] = 1'b1;
            last_flip[i] = n_edges;
          end
        end
      end
      risem = flip & ~dbm;
      dbm   = dbm ^ flip;
      tglm  = tglm ^ risem;
      ledm  = led_new;
      s2m   = s1m;
      s1m   = sw;
    end
  end

  // scoreboard: every cycle, DUT vs model
  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_sw_db", sw_db, dbm);
      chk("model_rise", rise, risem);
      chk("model_led", led, ledm);
    end
  end

  initial begin
    logic [W-1:0] prev;
    int pulses, cnt55, cnt00;

    // reset with switches held high
    rst = 1'b1; sw = 7'h7F; mode = 2'b00;
    tick(1);
    chk("rst_sw_db", sw_db, 7'h00);
    chk("rst_rise", rise, 7'h00);
    chk("rst_led", led, 7'h00);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("rel_db_e5", sw_db, 7'h00);
    tick(1);
    chk("rel_db_e6", sw_db, 7'h7F);
    chk("rel_rise_e6", rise, 7'h7F);
    chk("rel_led_e6", led, 7'h00);
    tick(1);
    chk("rel_led_e7", led, 7'h7F);
    chk("rel_rise_e7", rise, 7'h00);

    // glitch shorter than the debounce window
    sw = 7'h00;
    tick(10);
    sw = 7'h01;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) sw = 7'h00;
      tick(1);
      chk("glitch_db", sw_db, 7'h00);
      chk("glitch_rise", rise, 7'h00);
      chk("glitch_led", led, 7'h00);
    end

    // sweep in pass-through mode
    prev = 7'h00;
    for (int v = 0; v < 128; v++) begin
      sw = 7'(v);
      tick(6);
      chk("sweep_db", sw_db, 7'(v));
      chk("sweep_rise", rise, 7'(v) & ~prev);
      chk("sweep_led_old", led, prev);
      tick(1);
      chk("sweep_led", led, 7'(v));
      chk("sweep_rise_end", rise, 7'h00);
      tick(3);
      prev = 7'(v);
    end

    // toggle mode
    rst = 1'b1; sw = 7'h00;
    tick(2);
    rst = 1'b0; mode = 2'b01;
    tick(3);
    pulses = 0;
    for (int p = 0; p < 2; p++) begin
      sw = 7'h04;
      for (int k = 0; k < 10; k++) begin tick(1); if (rise[2]) pulses++; end
      chk("tgl_led_press", led, (p == 0) ? 7'h04 : 7'h00);
      sw = 7'h00;
      for (int k = 0; k < 10; k++) begin tick(1); if (rise[2]) pulses++; end
      chk("tgl_led_release", led, (p == 0) ? 7'h04 : 7'h00);
    end
    n_cmp++;
    if (pulses != 2) begin
      n_bad++;
      $display("FAIL tgl_pulses: got %0d expected 2", pulses);
    end

    // blink mode
    mode = 2'b10; sw = 7'h55;
    tick(10);
    cnt55 = 0; cnt00 = 0;
    for (int k = 0; k < 32; k++) begin
      tick(1);
      if (led == 7'h55) cnt55++;
      else if (led == 7'h00) cnt00++;
    end
`ifdef SW_LED_BLINK_EN
    chk("blink_on_cycles", 7'(cnt55), 7'd16);
    chk("blink_off_cycles", 7'(cnt00), 7'd16);
`else
    chk("blink_on_cycles", 7'(cnt55), 7'd32);
    chk("blink_off_cycles", 7'(cnt00), 7'd0);
`endif
    mode = 2'b11;
    tick(1);
    chk("off_led", led, 7'h00);
    mode = 2'b00;
    tick(1);
    chk("pass_led", led, 7'h55);

    // reset in the middle of a debounce count
    rst = 1'b1; sw = 7'h00;
    tick(2);
    rst = 1'b0;
    tick(3);
    sw = 7'h08;
    tick(4);
    chk("mid_db_pre", sw_db, 7'h00);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_db", sw_db, 7'h00);
    chk("mid_rst_led", led, 7'h00);
    rst = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (rise[3]) pulses++;
      if (k == 5) chk("mid_db_e5", sw_db, 7'h00);
      if (k == 6) begin
        chk("mid_db_e6", sw_db, 7'h08);
        chk("mid_rise_e6", rise, 7'h08);
      end
      if (k == 7) chk("mid_led_e7", led, 7'h08);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL mid_pulses: got %0d expected 1", pulses);
    end

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
